clr_sel_ctrl: RTL and testbench
===============================

Name: clr_sel_ctrl

Overview:
Generates the one-hot colour-select pulses (clr_sel) consumed by the colour-detect/highlight block. Its inputs are the DE1-SoC push keys and an optional auto-cycle timer. It synchronises and debounces the four active-low keys and converts each press into a single-cycle one-hot pulse. In auto mode it steps through the highlight modes, using the detector's ctrl_out fed back as ctrl_in.

Parameters:
DEB_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 2
AUTO_CYCLES, 100000000, cycles between auto-advance pulses (2 s at 50 MHz); minimum 2
SYNC_STAGES, 2, flops in each key synchroniser; minimum 2

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
key_n  in  4  raw asynchronous keys, active-low (0 = pressed)
auto_en  in  1  1 = auto-cycle enabled
ctrl_in  in  2  current mode from the detector (01 red, 00 green, 10 blue, 11 pass-through)
clr_sel  out  4  one-cycle one-hot select pulse; bit3 red, bit2 green, bit1 blue, bit0 pass-through
press_cnt  out  8  accepted key presses, wraps 255->0 (debug)

Behaviour:
- Reset: evaluated on posedge clk only, when rst=1. Required state after reset:
  - clr_sel=0, press_cnt=0.
  - Synchroniser flops and debounced levels all 1 (released).
  - Debounce counters and auto timer = 0.
- Reset mid-debounce aborts the count; no pulse is issued.
- A key held low through reset release is detected as a fresh press after the normal latency.
- Synchroniser: SYNC_STAGES flops per key; only the last stage feeds the debouncer.
- Debouncer, per key, with counter width $clog2(DEB_CYCLES):
  - If synced == stable: counter cleared.
  - Otherwise the counter increments.
  - On the cycle the counter equals DEB_CYCLES-1 while still disagreeing, stable takes the synced value and the counter clears.
  - A bounce (synced returns to stable) before that cycle clears the counter; no change is accepted.
- Press event: stable goes 1->0 for that key. Releases (0->1) generate nothing.
- Key pulse:
  - clr_sel is registered; it asserts one cycle after the event cycle, for exactly one cycle.
  - Latency from the first clock edge sampling key_n low is SYNC_STAGES+DEB_CYCLES+1 edges, given a clean input.
- Simultaneous events: the highest index wins (bit3 > bit2 > bit1 > bit0). Lower events that cycle are discarded. clr_sel is never multi-hot.
- press_cnt increments by 1 per cycle with any accepted event, including discarded simultaneous ones. Only one increment per cycle.
- Auto timer: counter width $clog2(AUTO_CYCLES).
  - Counts while auto_en=1.
  - Held at 0 while auto_en=0.
  - Cleared on any key event.
  - On reaching AUTO_CYCLES-1 it clears and issues an auto pulse the next cycle.
- Auto pulse selects the next mode from ctrl_in as sampled on the expiry cycle:
  - ctrl_in 01 -> clr_sel 0100 (green).
  - ctrl_in 00 -> 0010 (blue).
  - ctrl_in 10 -> 0001 (pass-through).
  - ctrl_in 11 -> 1000 (red).
- Key event and timer expiry in the same cycle: the key pulse is issued, the auto pulse is dropped, and the timer restarts from 0.
- Auto pulses do not change press_cnt.
- auto_en falling on the expiry cycle: the pulse is still issued (decision made on the expiry cycle), then the timer holds at 0.
- No combinational path from any input to clr_sel or press_cnt.

Test Plan:
(Bench sets DEB_CYCLES=4, AUTO_CYCLES=16, SYNC_STAGES=2.)
1. Reset with all keys released, then key_n[2] driven low cleanly at edge N -> clr_sel=0100 for exactly one cycle at edge N+7; press_cnt=1; releasing key_n[2] produces no pulse.
2. key_n[0] bounces low 2 cycles, high 1, low 2, then stays low -> no pulse during the bounce; one 0001 pulse 7 edges after the final stable-low start; press_cnt=1.
3. key_n[3] and key_n[1] fall on the same edge -> a single 1000 pulse; press_cnt=1; no 0010 pulse follows.
4. auto_en=1, no keys, ctrl_in stepped 01->00->10->11 after each pulse -> pulses 0100, 0010, 0001, 1000, spaced 16 cycles apart.
5. auto_en=1 with a key press whose event lands on the timer-expiry cycle -> only the key pulse is issued; the next auto pulse comes 16 cycles after the key event.
6. rst asserted for 1 cycle mid-debounce of key_n[1] with the key held low -> clr_sel=0 and press_cnt=0 after reset; one 0010 pulse at 7 edges after reset release; 256 presses wrap press_cnt to 0.

Source files
------------

// File: rtl/clr_sel_ctrl.sv
// Colour-select pulse generator: synchronises and debounces four active-low keys,
// turns presses into one-hot clr_sel pulses, and optionally auto-cycles modes.
module clr_sel_ctrl #(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned AUTO_CYCLES = 100000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic       auto_en,
  input  logic [1:0] ctrl_in,
  output logic [3:0] clr_sel,
  output logic [7:0] press_cnt
);

  localparam int unsigned DW = $clog2(DEB_CYCLES);
  localparam int unsigned AW = $clog2(AUTO_CYCLES);

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0][DW-1:0]          cnt_q, cnt_d;
  logic [3:0]                  stable_q, stable_d;
  logic [3:0]                  stable_prev_q;
  logic [3:0]                  evt_q, evt_d;
  logic [AW-1:0]               tmr_q, tmr_d;
  logic [3:0]                  clr_sel_q, clr_sel_d;
  logic [7:0]                  press_cnt_q, press_cnt_d;
  logic [3:0]                  synced;
  logic                        key_any;
  logic                        expire;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign key_any = |evt_q;
  assign expire  = (tmr_q == AW'(AUTO_CYCLES - 1));

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
  end

  // A level change is accepted only after DEB_CYCLES consecutive disagreeing cycles.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (synced[i] != stable_q[i]) begin
        if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          stable_d[i] = synced[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    evt_d = stable_prev_q & ~stable_q;
  end

  // Key events outrank a coincident timer expiry; the auto pulse is then dropped.
  always_comb begin
    clr_sel_d   = '0;
    press_cnt_d = press_cnt_q;
    tmr_d       = tmr_q + AW'(1);
    if (key_any || expire || !auto_en) begin
      tmr_d = '0;
    end
    if (key_any) begin
      press_cnt_d = press_cnt_q + 8'd1;
      if (evt_q[3])      clr_sel_d = 4'b1000;
      else if (evt_q[2]) clr_sel_d = 4'b0100;
      else if (evt_q[1]) clr_sel_d = 4'b0010;
      else               clr_sel_d = 4'b0001;
    end else if (expire) begin
      case (ctrl_in)
        2'b01:   clr_sel_d = 4'b0100;
        2'b00:   clr_sel_d = 4'b0010;
        2'b10:   clr_sel_d = 4'b0001;
        default: clr_sel_d = 4'b1000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '1;
      cnt_q         <= '0;
      stable_q      <= '1;
      stable_prev_q <= '1;
      evt_q         <= '0;
      tmr_q         <= '0;
      clr_sel_q     <= '0;
      press_cnt_q   <= '0;
    end else begin
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      evt_q         <= evt_d;
      tmr_q         <= tmr_d;
      clr_sel_q     <= clr_sel_d;
      press_cnt_q   <= press_cnt_d;
    end
  end

  assign clr_sel   = clr_sel_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_clr_sel_ctrl.sv
// Directed bench for clr_sel_ctrl: expected pulses are queued with their edge
// number and every negedge checks clr_sel against the queue head (or zero).
module tb_clr_sel_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic       auto_en;
  logic [1:0] ctrl_in;
  logic [3:0] clr_sel;
  logic [7:0] press_cnt;

  typedef struct {
    int         edge_n;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  clr_sel_ctrl #(
    .DEB_CYCLES (4),
    .AUTO_CYCLES(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .auto_en  (auto_en),
    .ctrl_in  (ctrl_in),
    .clr_sel  (clr_sel),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].edge_n == edge_cnt) begin
        check("clr_sel_pulse", {4'h0, clr_sel}, {4'h0, sb[0].val});
        void'(sb.pop_front());
      end else begin
        check("clr_sel_idle", {4'h0, clr_sel}, 8'h00);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int e, input logic [3:0] v);
    exp_t x;
    x.edge_n = e;
    x.val    = v;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    key_n   = 4'hF;
    auto_en = 1'b0;
    ctrl_in = 2'b00;
    wait_edges(3);
    check("reset_clr_sel", {4'h0, clr_sel}, 8'h00);
    check("reset_press_cnt", press_cnt, 8'h00);
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  int n0;
  int a0;

  initial begin
    rst     = 1'b1;
    key_n   = 4'hF;
    auto_en = 1'b0;
    ctrl_in = 2'b00;
    #1;

    // 1: clean press of key 2, release gives nothing
    do_reset();
    wait_edges(2);
    key_n[2] = 1'b0;
    n0 = edge_cnt + 1;
    push(n0 + 7, 4'b0100);
    wait_until(n0 + 10);
    check("t1_press_cnt", press_cnt, 8'd1);
    key_n[2] = 1'b1;
    wait_edges(14);
    check("t1_after_release", press_cnt, 8'd1);

    // 2: bounce on key 0
    do_reset();
    wait_edges(2);
    key_n[0] = 1'b0;
    wait_edges(2);
    key_n[0] = 1'b1;
    wait_edges(1);
    key_n[0] = 1'b0;
    n0 = edge_cnt + 1;
    push(n0 + 7, 4'b0001);
    wait_until(n0 + 12);
    check("t2_press_cnt", press_cnt, 8'd1);

    // 3: simultaneous keys 3 and 1
    do_reset();
    wait_edges(2);
    key_n = 4'b0101;
    n0 = edge_cnt + 1;
    push(n0 + 7, 4'b1000);
    wait_until(n0 + 14);
    check("t3_press_cnt", press_cnt, 8'd1);
    key_n = 4'hF;
    wait_edges(10);

    // 4: auto cycle through modes
    do_reset();
    wait_edges(2);
    ctrl_in = 2'b01;
    auto_en = 1'b1;
    a0 = edge_cnt + 1;
    push(a0 + 15, 4'b0100);
    wait_until(a0 + 15);
    ctrl_in = 2'b00;
    push(a0 + 31, 4'b0010);
    wait_until(a0 + 31);
    ctrl_in = 2'b10;
    push(a0 + 47, 4'b0001);
    wait_until(a0 + 47);
    ctrl_in = 2'b11;
    push(a0 + 63, 4'b1000);
    wait_until(a0 + 63);
    auto_en = 1'b0;
    check("t4_press_cnt", press_cnt, 8'd0);
    wait_edges(40);

    // 5: key event coincides with expiry; then auto_en drops on an expiry cycle
    do_reset();
    wait_edges(2);
    ctrl_in = 2'b01;
    auto_en = 1'b1;
    a0 = edge_cnt + 1;
    wait_until(a0 + 7);
    key_n[3] = 1'b0;
    push(a0 + 15, 4'b1000);
    wait_until(a0 + 15);
    ctrl_in = 2'b00;
    push(a0 + 31, 4'b0010);
    wait_until(a0 + 31);
    check("t5_press_cnt", press_cnt, 8'd1);
    ctrl_in = 2'b10;
    push(a0 + 47, 4'b0001);
    wait_until(a0 + 46);
    auto_en = 1'b0;
    wait_until(a0 + 80);
    check("t5_press_cnt_end", press_cnt, 8'd1);

    // 6: reset mid-debounce with key 1 held, then wrap press_cnt
    do_reset();
    wait_edges(2);
    key_n[1] = 1'b0;
    n0 = edge_cnt + 1;
    wait_until(n0 + 2);
    rst = 1'b1;
    wait_until(n0 + 3);
    check("t6_rst_clr_sel", {4'h0, clr_sel}, 8'h00);
    check("t6_rst_press_cnt", press_cnt, 8'h00);
    rst = 1'b0;
    push(n0 + 11, 4'b0010);
    wait_until(n0 + 13);
    check("t6_press_cnt_1", press_cnt, 8'd1);
    key_n[1] = 1'b1;
    wait_edges(9);
    for (int i = 2; i <= 256; i++) begin
      key_n[1] = 1'b0;
      n0 = edge_cnt + 1;
      push(n0 + 7, 4'b0010);
      wait_edges(9);
      check("t6_press_cnt", press_cnt, 8'(i));
      key_n[1] = 1'b1;
      wait_edges(9);
    end
    check("t6_wrap", press_cnt, 8'd0);

    wait_edges(4);
    check("scoreboard_empty", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
